line_xfer: RTL



---
 rtl/line_xfer_pkg.sv | 20 ++
 rtl/line_xfer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/line_xfer_pkg.sv
// Shared types and default sizes for the cache-line transfer engine.
package line_xfer_pkg;

    localparam int LINE_WORDS_DEF = 4;
    localparam int ADDR_W_DEF     = 20;

    typedef enum logic {
        OP_FILL = 1'b0,
        OP_WB   = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_RESP
    } state_e;

endpackage

// File: rtl/line_xfer.sv
// Cache-line fill/writeback engine in front of a 1-cycle-latency byte-write RAM.
// Define LINE_XFER_CRIT_FIRST_EN to issue fills critical-word-first and pulse crit_valid_o.
module line_xfer
    import line_xfer_pkg::*;
#(
    parameter int WORDS  = LINE_WORDS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_op_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [WORDS*32-1:0]   wb_line_i,
    output logic [WORDS*32-1:0]   fill_line_o,
    output logic                  done_o,
    output logic                  crit_valid_o,
    output logic [31:0]           crit_word_o,
    output logic                  ram_we_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [31:0]           ram_din_o,
    output logic [3:0]            ram_be_o,
    input  logic [31:0]           ram_dout_i
);

    localparam int CNT_W = $clog2(WORDS);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [ADDR_W-CNT_W-1:0]  base_hi_q;
    logic [31:0]              line_q [WORDS];
    logic [CNT_W-1:0]         rd_idx;
    logic [CNT_W-1:0]         cap_idx;
    logic                     accept;
    logic                     capture;

    assign accept  = req_valid_i && (state_q == ST_IDLE);
    // Read data lags its address by one beat, so captures run from READ beat 1 through DRAIN.
    assign capture = ((state_q == ST_READ) && (cnt_q != '0)) || (state_q == ST_DRAIN);

`ifdef LINE_XFER_CRIT_FIRST_EN
    logic [CNT_W-1:0] offset_q;
    logic             crit_valid_q;
    logic [31:0]      crit_word_q;

    assign rd_idx  = cnt_q + offset_q;
    assign cap_idx = cnt_q - CNT_W'(1) + offset_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_q     <= '0;
            crit_valid_q <= 1'b0;
            crit_word_q  <= '0;
        end else begin
            if (accept)
                offset_q <= req_addr_i[CNT_W-1:0];
            crit_valid_q <= (state_q == ST_READ) && (cnt_q == CNT_W'(1));
            if ((state_q == ST_READ) && (cnt_q == CNT_W'(1)))
                crit_word_q <= ram_dout_i;
        end
    end

    assign crit_valid_o = crit_valid_q;
    assign crit_word_o  = crit_word_q;
`else
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr_i[CNT_W-1:0];
    assign rd_idx          = cnt_q;
    assign cap_idx         = cnt_q - CNT_W'(1);
    assign crit_valid_o    = 1'b0;
    assign crit_word_o     = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (op_e'(req_op_i) == OP_WB) ? ST_WRITE : ST_READ;
            ST_WRITE: if (&cnt_q) state_d = ST_RESP;
            ST_READ:  if (&cnt_q) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Line base keeps its low bits implicit, so base + idx can never carry out of the line.
    always_comb begin
        req_ready_o = 1'b0;
        done_o      = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = '0;
        ram_din_o   = '0;
        case (state_q)
            ST_IDLE:  req_ready_o = 1'b1;
            ST_WRITE: begin
                ram_we_o   = 1'b1;
                ram_be_o   = 4'hF;
                ram_addr_o = {base_hi_q, cnt_q};
                ram_din_o  = line_q[cnt_q];
            end
            ST_READ:  ram_addr_o = {base_hi_q, rd_idx};
            ST_RESP:  done_o = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            base_hi_q <= '0;
            for (int i = 0; i < WORDS; i++)
                line_q[i] <= '0;
        end else if (accept) begin
            cnt_q     <= '0;
            base_hi_q <= req_addr_i[ADDR_W-1:CNT_W];
            for (int i = 0; i < WORDS; i++)
                line_q[i] <= wb_line_i[32*i +: 32];
        end else if ((state_q == ST_WRITE) || (state_q == ST_READ)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_fill
        logic [31:0] word_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                word_q <= '0;
            else if (capture && (cap_idx == CNT_W'(gi)))
                word_q <= ram_dout_i;
        end

        assign fill_line_o[32*gi +: 32] = word_q;
    end

endmodule
